// File: rtl/spi_reg_bank_pkg.sv
// Shared definitions for the SPI register bank: system address map,
// command byte layout and the transaction FSM state type.
package regs_pkg;

    // Read-only system registers
    localparam logic [6:0] RegSysId0     = 7'h00;
    localparam logic [6:0] RegSysId1     = 7'h01;
    localparam logic [6:0] RegSysId2     = 7'h02;
    localparam logic [6:0] RegSysId3     = 7'h03;
    localparam logic [6:0] RegSysId4     = 7'h04;
    localparam logic [6:0] RegSysVersion = 7'h05;
    localparam logic [6:0] RegSysStatus  = 7'h06;

    // Bit of the command byte that selects write (1) or read (0)
    localparam int CmdWriteBit = 7;

    // Identity string served at RegSysId0..RegSysId4
    localparam logic [7:0] SysIdChar0 = 8'h41; // "A"
    localparam logic [7:0] SysIdChar1 = 8'h52; // "R"
    localparam logic [7:0] SysIdChar2 = 8'h47; // "G"
    localparam logic [7:0] SysIdChar3 = 8'h55; // "U"
    localparam logic [7:0] SysIdChar4 = 8'h53; // "S"

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CMD   = 2'd1,
        WRITE = 2'd2,
        READ  = 2'd3
    } reg_bank_state_t;

endpackage

// File: rtl/spi_reg_bank.sv
// SPI register bank behind spi_slave. A transaction is a command byte
// (bit 7 = write, bits 6:0 = start address) followed by data bytes at
// auto-incrementing addresses. Serves the identity/version/status
// registers and NUM_RW writable control registers with write strobes.
//
// Handshake: rx_byte is consumed in exactly the cycle rx_valid is high
// while cs_n is low; there is no back-pressure, so a pulse on every
// cycle is accepted. A cycle with cs_n high discards rx_valid entirely.
// tx_byte is registered and always holds the byte for the current
// address so spi_slave can load it at the next SPI byte boundary.
module spi_reg_bank
    import regs_pkg::*;
#(
    parameter int                     NUM_RW   = 8,
    parameter logic [6:0]             RW_BASE  = 7'h10,
    parameter logic [7:0]             VERSION  = 8'h01,
    parameter logic [NUM_RW*8-1:0]    RW_RESET = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cs_n,
    input  logic [7:0]            rx_byte,
    input  logic                  rx_valid,
    output logic [7:0]            tx_byte,
    output logic [NUM_RW*8-1:0]   reg_q,
    output logic [NUM_RW-1:0]     wr_stb,
    output reg_bank_state_t       state_dbg
);

    reg_bank_state_t   state;
    logic [6:0]        addr;
    logic [6:0]        addr_nxt;
    logic [7:0]        err_cnt;
    logic [7:0]        rd_data;
    logic [NUM_RW-1:0] win_hit;
    logic              in_window;
    logic              do_write;
    logic              err_clr;
    logic              err_inc;

    assign state_dbg = state;

    // Decode the current byte: which writable register (if any) is hit,
    // whether it is a write, and how the error counter reacts.
    always_comb begin
        win_hit = '0;
        for (int i = 0; i < NUM_RW; i++) begin
            if (int'(addr) == int'(RW_BASE) + i) begin
                win_hit[i] = 1'b1;
            end
        end
        in_window = |win_hit;
        do_write  = !cs_n && (state == WRITE) && rx_valid;
        err_clr   = do_write && (addr == RegSysStatus);
        err_inc   = do_write && !err_clr && !in_window;
    end

    // Address the bank will hold after this cycle; 7-bit arithmetic wraps 0x7F to 0x00.
    always_comb begin
        addr_nxt = addr;
        if (!cs_n && rx_valid) begin
            if (state == CMD) begin
                addr_nxt = rx_byte[6:0];
            end else if (state == WRITE || state == READ) begin
                addr_nxt = addr + 7'd1;
            end
        end
    end

    // Read mux over the full map, looked up at the upcoming address.
    always_comb begin
        rd_data = 8'h00;
        case (addr_nxt)
            RegSysId0:     rd_data = SysIdChar0;
            RegSysId1:     rd_data = SysIdChar1;
            RegSysId2:     rd_data = SysIdChar2;
            RegSysId3:     rd_data = SysIdChar3;
            RegSysId4:     rd_data = SysIdChar4;
            RegSysVersion: rd_data = VERSION;
            RegSysStatus:  rd_data = err_cnt;
            default: begin
                for (int i = 0; i < NUM_RW; i++) begin
                    if (int'(addr_nxt) == int'(RW_BASE) + i) begin
                        rd_data = reg_q[8*i +: 8];
                    end
                end
            end
        endcase
    end

    // Transaction FSM with registered address and tx_byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            addr    <= 7'h00;
            tx_byte <= 8'h00;
        end else if (cs_n) begin
            state   <= IDLE;
            tx_byte <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    state   <= CMD;
                    tx_byte <= 8'h00;
                end
                CMD: begin
                    if (rx_valid) begin
                        state   <= rx_byte[CmdWriteBit] ? WRITE : READ;
                        addr    <= addr_nxt;
                        tx_byte <= rd_data;
                    end else begin
                        tx_byte <= 8'h00;
                    end
                end
                WRITE, READ: begin
                    addr    <= addr_nxt;
                    tx_byte <= rd_data;
                end
                default: begin
                    state   <= IDLE;
                    tx_byte <= 8'h00;
                end
            endcase
        end
    end

    // Writable registers and their one-cycle write strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_q  <= RW_RESET;
            wr_stb <= '0;
        end else begin
            wr_stb <= do_write ? win_hit : '0;
            for (int i = 0; i < NUM_RW; i++) begin
                if (do_write && win_hit[i]) begin
                    reg_q[8*i +: 8] <= rx_byte;
                end
            end
        end
    end

    // Saturating error counter; a clear-write takes priority over an increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= 8'h00;
        end else if (err_clr) begin
            err_cnt <= 8'h00;
        end else if (err_inc && err_cnt != 8'hFF) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_spi_reg_bank.sv
// Bench for spi_reg_bank: table of SPI bytes with the tx_byte each one
// should produce, plus hand-written sequences for strobes, back-to-back
// bytes, saturation, abort and asynchronous reset.
module tb_spi_reg_bank;
    import regs_pkg::*;

    localparam int              NUM_RW   = 8;
    localparam logic [63:0]     RW_RESET = 64'h7766554433221100;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic                cs_n;
    logic [7:0]          rx_byte;
    logic                rx_valid;
    logic [7:0]          tx_byte;
    logic [NUM_RW*8-1:0] reg_q;
    logic [NUM_RW-1:0]   wr_stb;
    reg_bank_state_t     state_dbg;

    spi_reg_bank #(
        .NUM_RW   (NUM_RW),
        .RW_BASE  (7'h10),
        .VERSION  (8'h01),
        .RW_RESET (RW_RESET)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cs_n      (cs_n),
        .rx_byte   (rx_byte),
        .rx_valid  (rx_valid),
        .tx_byte   (tx_byte),
        .reg_q     (reg_q),
        .wr_stb    (wr_stb),
        .state_dbg (state_dbg)
    );

    // ---------------- scoreboard ----------------
    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0]        exp_q[$];
    logic [NUM_RW-1:0] stb_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Record every strobe cycle so pulse width and order can be checked.
    always @(negedge clk) begin
        if (rst_n && wr_stb != '0) stb_q.push_back(wr_stb);
    end

    // ---------------- driver tasks ----------------
    task automatic start_txn();
        @(negedge clk);
        cs_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_tx", 64'(tx_byte), 64'h00);
        check("idle_state", 64'(state_dbg), 64'(IDLE));
        cs_n = 1'b0;
        repeat (2) @(negedge clk);
        check("cmd_state", 64'(state_dbg), 64'(CMD));
    endtask

    task automatic send(input logic [7:0] b, input logic [7:0] exp_tx);
        logic [7:0] e;
        exp_q.push_back(exp_tx);
        @(negedge clk);
        rx_byte  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        repeat (2) @(negedge clk);
        e = exp_q.pop_front();
        check("tx_byte", 64'(tx_byte), 64'(e));
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic       new_txn;
        logic [7:0] data;
        logic [7:0] exp_tx;
    } vec_t;
    vec_t vecs[$];

    function automatic void add(input logic n, input logic [7:0] d, input logic [7:0] e);
        vec_t v;
        v.new_txn = n;
        v.data    = d;
        v.exp_tx  = e;
        vecs.push_back(v);
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n    = 1'b0;
        cs_n     = 1'b1;
        rx_byte  = 8'h00;
        rx_valid = 1'b0;

        // ID read: "ARGUS", version, err_cnt
        add(1, 8'h00, 8'h41); add(0, 8'hFF, 8'h52); add(0, 8'hFF, 8'h47);
        add(0, 8'hFF, 8'h55); add(0, 8'hFF, 8'h53); add(0, 8'hFF, 8'h01);
        add(0, 8'hFF, 8'h00);
        // Burst write at 0x10; tx echoes pre-write contents
        add(1, 8'h90, 8'h00); add(0, 8'hAA, 8'h11); add(0, 8'h55, 8'h22);
        add(0, 8'h0F, 8'h33);
        // Error counting into the ID region, read, clear, read
        add(1, 8'h81, 8'h52); add(0, 8'h01, 8'h47); add(0, 8'h02, 8'h55);
        add(0, 8'h03, 8'h53); add(1, 8'h06, 8'h03); add(1, 8'h86, 8'h03);
        add(0, 8'h00, 8'h00); add(1, 8'h06, 8'h00);
        // Address wrap 0x7F -> 0x00
        add(1, 8'h7F, 8'h00); add(0, 8'hFF, 8'h41); add(0, 8'hFF, 8'h52);
        // Read back the written registers
        add(1, 8'h10, 8'hAA); add(0, 8'hFF, 8'h55); add(0, 8'hFF, 8'h0F);
        add(0, 8'hFF, 8'h33);
        // Window edges: 0x18 is outside, 0x17 is the last register, 0x0F below
        add(1, 8'h98, 8'h00); add(0, 8'h12, 8'h00); add(1, 8'h06, 8'h01);
        add(1, 8'h97, 8'h77); add(0, 8'h5A, 8'h00); add(1, 8'h17, 8'h5A);
        add(1, 8'h0F, 8'h00); add(1, 8'h06, 8'h01);

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_tx", 64'(tx_byte), 64'h00);
        check("rst_stb", 64'(wr_stb), 64'h00);
        check("rst_regq", 64'(reg_q), RW_RESET);
        check("rst_state", 64'(state_dbg), 64'(IDLE));
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].new_txn) start_txn();
            send(vecs[i].data, vecs[i].exp_tx);
        end

        check("regq_after_table", 64'(reg_q), 64'h5A66554433_0F55AA);
        check("stb_count", 64'(stb_q.size()), 64'd4);
        if (stb_q.size() == 4) begin
            check("stb0", 64'(stb_q[0]), 64'h01);
            check("stb1", 64'(stb_q[1]), 64'h02);
            check("stb2", 64'(stb_q[2]), 64'h04);
            check("stb3", 64'(stb_q[3]), 64'h80);
        end
        stb_q.delete();

        // Back-to-back bytes: command and two data bytes on consecutive cycles
        start_txn();
        @(negedge clk);
        rx_byte = 8'h92; rx_valid = 1'b1;
        @(negedge clk);
        rx_byte = 8'hC1;
        @(negedge clk);
        rx_byte = 8'hC2;
        @(negedge clk);
        rx_valid = 1'b0;
        @(negedge clk);
        check("b2b_reg2", 64'(reg_q[23:16]), 64'hC1);
        check("b2b_reg3", 64'(reg_q[31:24]), 64'hC2);
        check("b2b_tx", 64'(tx_byte), 64'h44);
        check("b2b_stb_count", 64'(stb_q.size()), 64'd2);
        if (stb_q.size() == 2) begin
            check("b2b_stb0", 64'(stb_q[0]), 64'h04);
            check("b2b_stb1", 64'(stb_q[1]), 64'h08);
        end
        stb_q.delete();

        // Error counter saturation: 270 dropped writes in the unmapped 0x60 region
        for (int t = 0; t < 9; t++) begin
            start_txn();
            send(8'hE0, 8'h00);
            for (int k = 0; k < 30; k++) send(8'($urandom_range(0, 255)), 8'h00);
        end
        start_txn(); send(8'h06, 8'hFF);
        start_txn(); send(8'h86, 8'hFF); send(8'h00, 8'h00);
        start_txn(); send(8'h06, 8'h00);

        // Abort: cs_n rises in the same cycle as the second data byte
        stb_q.delete();
        start_txn();
        send(8'h90, 8'hAA);
        send(8'h11, 8'h55);
        @(negedge clk);
        rx_byte = 8'h22; rx_valid = 1'b1; cs_n = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        @(negedge clk);
        check("abort_reg0", 64'(reg_q[7:0]), 64'h11);
        check("abort_reg1", 64'(reg_q[15:8]), 64'h55);
        check("abort_tx", 64'(tx_byte), 64'h00);
        check("abort_state", 64'(state_dbg), 64'(IDLE));
        check("abort_stb_count", 64'(stb_q.size()), 64'd1);
        // The first byte of the next transaction must act as a command
        start_txn();
        send(8'h91, 8'h55);
        check("post_abort_state", 64'(state_dbg), 64'(WRITE));
        check("post_abort_reg1", 64'(reg_q[15:8]), 64'h55);
        check("post_abort_stb_count", 64'(stb_q.size()), 64'd1);

        // Async reset in the middle of a write burst
        start_txn();
        send(8'hA0, 8'h00);
        send(8'h33, 8'h00);
        start_txn();
        send(8'h90, 8'h11);
        send(8'h77, 8'h55);
        @(negedge clk);
        rx_byte = 8'h88; rx_valid = 1'b1;
        @(posedge clk);
        #2;
        check("pre_rst_reg1", 64'(reg_q[15:8]), 64'h88);
        check("pre_rst_stb", 64'(wr_stb), 64'h02);
        rst_n = 1'b0;
        #1;
        check("async_rst_tx", 64'(tx_byte), 64'h00);
        check("async_rst_stb", 64'(wr_stb), 64'h00);
        check("async_rst_regq", 64'(reg_q), RW_RESET);
        check("async_rst_state", 64'(state_dbg), 64'(IDLE));
        rx_valid = 1'b0;
        cs_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        start_txn(); send(8'h06, 8'h00);
        start_txn(); send(8'h11, 8'h11);
        @(negedge clk);
        cs_n = 1'b1;
        repeat (2) @(negedge clk);

        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
